pll_phase_stepper: RTL and testbench

Sequencer for the trigger-board PLL dynamic phase-shift port. Accepts a request (counter select, direction, step count) from the serial command processor. Drives phasecounterselect/phaseupdown/phasestep/scanclk through the PLL step protocol once per step, paced by the PLL's phasedone handshake. Reports completion, progress and a timeout error.

---
 rtl/pll_phase_stepper.sv | 190 +++++++++++++++++++
 tb/tb_pll_phase_stepper.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_phase_stepper.sv
// pll_phase_stepper: drives the PLL dynamic phase-shift port one step
// at a time, paced by the PLL phasedone handshake, with timeout and abort.
module pll_phase_stepper #(
    parameter int SCAN_HALF = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req,
    input  logic [2:0] req_sel,
    input  logic       req_up,
    input  logic [7:0] req_nsteps,
    input  logic       abort,
    input  logic       phasedone,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] steps_done,
    output logic [2:0] phasecounterselect,
    output logic       phaseupdown,
    output logic       phasestep,
    output logic       scanclk
);

    localparam logic [7:0]  SH_M1  = 8'(SCAN_HALF - 1);
    localparam logic [8:0]  GAP_M1 = 9'(2 * SCAN_HALF - 1);
    localparam logic [15:0] TO_M1  = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        WAITDONE,
        GAP
    } state_t;

    state_t      state_q;
    logic        pd_meta_q;
    logic        pd_s_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [7:0]  steps_q;
    logic [7:0]  nsteps_q;
    logic [2:0]  sel_q;
    logic        up_q;
    logic        pstep_q;
    logic        sclk_q;
    logic [7:0]  scan_cnt_q;
    logic [1:0]  tog_q;
    logic [8:0]  gap_cnt_q;
    logic [15:0] to_cnt_q;
    logic        seen_low_q;
    logic [7:0]  steps_inc;
    logic        scan_hit;

    assign steps_inc = steps_q + 8'd1;
    assign scan_hit  = (scan_cnt_q == SH_M1);

    // Two-flop synchronizer for the asynchronous phasedone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pd_meta_q <= 1'b1;
            pd_s_q    <= 1'b1;
        end else begin
            pd_meta_q <= phasedone;
            pd_s_q    <= pd_meta_q;
        end
    end

    // Step sequencer with registered PLL-side and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            steps_q    <= 8'd0;
            nsteps_q   <= 8'd0;
            sel_q      <= 3'b000;
            up_q       <= 1'b1;
            pstep_q    <= 1'b0;
            sclk_q     <= 1'b0;
            scan_cnt_q <= 8'd0;
            tog_q      <= 2'd0;
            gap_cnt_q  <= 9'd0;
            to_cnt_q   <= 16'd0;
            seen_low_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort && state_q != IDLE) begin
                pstep_q <= 1'b0;
                sclk_q  <= 1'b0;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        sclk_q  <= 1'b0;
                        pstep_q <= 1'b0;
                        if (req) begin
                            if (req_nsteps == 8'd0) begin
                                done_q <= 1'b1;
                            end else begin
                                sel_q      <= req_sel;
                                up_q       <= req_up;
                                nsteps_q   <= req_nsteps;
                                steps_q    <= 8'd0;
                                err_q      <= 1'b0;
                                busy_q     <= 1'b1;
                                pstep_q    <= 1'b1;
                                scan_cnt_q <= 8'd0;
                                tog_q      <= 2'd0;
                                state_q    <= ASSERT;
                            end
                        end
                    end
                    ASSERT: begin
                        if (scan_hit) begin
                            scan_cnt_q <= 8'd0;
                            sclk_q     <= ~sclk_q;
                            tog_q      <= tog_q + 2'd1;
                            if (tog_q == 2'd3) begin
                                pstep_q    <= 1'b0;
                                to_cnt_q   <= 16'd0;
                                seen_low_q <= 1'b0;
                                state_q    <= WAITDONE;
                            end
                        end else begin
                            scan_cnt_q <= scan_cnt_q + 8'd1;
                        end
                    end
                    WAITDONE: begin
                        if (scan_hit) begin
                            scan_cnt_q <= 8'd0;
                            sclk_q     <= ~sclk_q;
                        end else begin
                            scan_cnt_q <= scan_cnt_q + 8'd1;
                        end
                        if (pd_s_q && seen_low_q) begin
                            steps_q <= steps_inc;
                            sclk_q  <= 1'b0;
                            if (steps_inc == nsteps_q) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end else begin
                                gap_cnt_q <= 9'd0;
                                state_q   <= GAP;
                            end
                        end else if (to_cnt_q == TO_M1) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            sclk_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            to_cnt_q <= to_cnt_q + 16'd1;
                            if (!pd_s_q) begin
                                seen_low_q <= 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        sclk_q <= 1'b0;
                        if (gap_cnt_q == GAP_M1) begin
                            pstep_q    <= 1'b1;
                            scan_cnt_q <= 8'd0;
                            tog_q      <= 2'd0;
                            state_q    <= ASSERT;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 9'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign err                = err_q;
    assign steps_done         = steps_q;
    assign phasecounterselect = sel_q;
    assign phaseupdown        = up_q;
    assign phasestep          = pstep_q;
    assign scanclk            = sclk_q;

endmodule

// File: tb/tb_pll_phase_stepper.sv
// tb_pll_phase_stepper: randomized requests against a behavioural PLL
// model and protocol-level expectations for the phase stepper.
module tb_pll_phase_stepper;

    localparam int SH = 4;
    localparam int TO = 64;

    logic       clk;
    logic       reset_n;
    logic       req;
    logic [2:0] req_sel;
    logic       req_up;
    logic [7:0] req_nsteps;
    logic       abort;
    logic       phasedone;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] steps_done;
    logic [2:0] phasecounterselect;
    logic       phaseupdown;
    logic       phasestep;
    logic       scanclk;

    pll_phase_stepper #(
        .SCAN_HALF(SH),
        .TIMEOUT  (TO)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req               (req),
        .req_sel           (req_sel),
        .req_up            (req_up),
        .req_nsteps        (req_nsteps),
        .abort             (abort),
        .phasedone         (phasedone),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .steps_done        (steps_done),
        .phasecounterselect(phasecounterselect),
        .phaseupdown       (phaseupdown),
        .phasestep         (phasestep),
        .scanclk           (scanclk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // PLL model: phasedone drops after each phasestep fall for pll_low clks
    bit pll_en  = 1'b1;
    int pll_low = 20;
    initial begin
        phasedone = 1'b1;
        forever begin
            @(negedge phasestep);
            if (pll_en) begin
                @(posedge clk);
                #1 phasedone = 1'b0;
                repeat (pll_low) @(posedge clk);
                #1 phasedone = 1'b1;
            end
        end
    end

    // Protocol monitor: pulse widths, gaps, done pulses, output stability
    int cyc = 0, n_pulse = 0, n_badlen = 0, n_short = 0;
    int n_done = 0, n_wide = 0, n_unst = 0;
    int last_fall = 0, last_done = 0, ps_len = 0, low_len = 0;
    logic ps_prev = 1'b0, done_prev = 1'b0;
    logic [2:0] exp_sel = 3'd0;
    logic exp_up = 1'b1;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!busy) low_len = 0;
            if (phasestep) ps_len++;
            if (phasestep && !ps_prev) begin
                if (low_len > 0 && low_len < 2 * SH) n_short++;
                low_len = 0;
            end
            if (!phasestep && busy) low_len++;
            if (!phasestep && ps_prev) begin
                n_pulse++;
                if (ps_len != 4 * SH) n_badlen++;
                ps_len = 0;
                last_fall = cyc;
            end
            if (done) begin
                if (done_prev) n_wide++;
                else n_done++;
                last_done = cyc;
            end
            if (busy && (phasecounterselect !== exp_sel ||
                         phaseupdown !== exp_up)) n_unst++;
            ps_prev   = phasestep;
            done_prev = done;
        end
    end

    task automatic step_clk(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic start(input int sel, input int up, input int n);
        req_sel    = 3'(sel);
        req_up     = 1'(up);
        req_nsteps = 8'(n);
        if (n != 0) begin
            exp_sel = 3'(sel);
            exp_up  = 1'(up);
        end
        req = 1'b1;
        step_clk(1);
        req = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            step_clk(1);
        end
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    task automatic run_req(input int sel, input int up, input int n,
                           input int low);
        int p0, b0, s0, d0, w0, u0;
        bit ok;
        pll_en  = 1'b1;
        pll_low = low;
        p0 = n_pulse; b0 = n_badlen; s0 = n_short;
        d0 = n_done;  w0 = n_wide;   u0 = n_unst;
        start(sel, up, n);
        chk("acc_busy", int'(busy), 1);
        chk("acc_pstep", int'(phasestep), 1);
        chk("acc_sel", int'(phasecounterselect), sel);
        chk("acc_up", int'(phaseupdown), up);
        chk("acc_err", int'(err), 0);
        wait_done(n * (6 * SH + low + 16) + 50, ok);
        if (ok) begin
            chk("fin_busy", int'(busy), 0);
            chk("fin_steps", int'(steps_done), n);
            chk("fin_err", int'(err), 0);
        end
        step_clk(1);
        chk("done_1cyc", int'(done), 0);
        chk("pulses", n_pulse - p0, n);
        chk("pulse_len", n_badlen - b0, 0);
        chk("gap_len", n_short - s0, 0);
        chk("done_cnt", n_done - d0, 1);
        chk("done_wide", n_wide - w0, 0);
        chk("hold_selup", n_unst - u0, 0);
    endtask

    initial begin
        bit ok;
        int p0, d0, delta;
        reset_n    = 1'b0;
        req        = 1'b0;
        req_sel    = 3'd0;
        req_up     = 1'b0;
        req_nsteps = 8'd0;
        abort      = 1'b0;
        step_clk(3);
        reset_n = 1'b1;
        step_clk(3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_steps", int'(steps_done), 0);
        chk("rst_sel", int'(phasecounterselect), 0);
        chk("rst_up", int'(phaseupdown), 1);
        chk("rst_pstep", int'(phasestep), 0);
        chk("rst_sclk", int'(scanclk), 0);

        // reset mid-ASSERT while scanclk is high
        start(3, 1, 2);
        step_clk(SH);
        chk("mid_sclk_hi", int'(scanclk), 1);
        reset_n = 1'b0;
        #1;
        chk("arst_pstep", int'(phasestep), 0);
        chk("arst_sclk", int'(scanclk), 0);
        chk("arst_busy", int'(busy), 0);
        #2 reset_n = 1'b1;
        step_clk(40);
        chk("arst_steps", int'(steps_done), 0);

        // single step, then three steps down
        run_req(3, 1, 1, 20);
        run_req(5, 0, 3, 20);

        // randomized requests
        for (int i = 0; i < 6; i++) begin
            run_req(int'($urandom_range(6, 0)), int'($urandom_range(1, 0)),
                    int'($urandom_range(4, 1)), int'($urandom_range(30, 3)));
        end

        // timeout: phasedone never drops
        pll_en = 1'b0;
        p0 = n_pulse;
        start(2, 1, 2);
        wait_done(4 * SH + TO + 20, ok);
        if (ok) begin
            chk("to_err", int'(err), 1);
            chk("to_steps", int'(steps_done), 0);
            chk("to_busy", int'(busy), 0);
            delta = last_done - last_fall;
            chk("to_latency", int'(delta >= TO - 2 && delta <= TO + 2), 1);
        end
        step_clk(2);
        chk("to_pulses", n_pulse - p0, 1);
        chk("to_err_sticky", int'(err), 1);
        run_req(1, 0, 1, 10);

        // abort in step 2 WAITDONE, ignored reqs while busy
        pll_en  = 1'b1;
        pll_low = 20;
        p0 = n_pulse;
        d0 = n_done;
        start(4, 1, 5);
        step_clk(5);
        req_sel    = 3'd6;
        req_up     = 1'b0;
        req_nsteps = 8'd7;
        req = 1'b1;
        step_clk(1);
        req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (n_pulse - p0 >= 2) begin
                ok = 1'b1;
                break;
            end
            step_clk(1);
        end
        chk("ab_reach_step2", int'(ok), 1);
        step_clk(3);
        req = 1'b1;
        step_clk(1);
        req = 1'b0;
        abort = 1'b1;
        step_clk(1);
        abort = 1'b0;
        chk("ab_done", int'(done), 1);
        chk("ab_busy", int'(busy), 0);
        chk("ab_steps", int'(steps_done), 1);
        chk("ab_pstep", int'(phasestep), 0);
        chk("ab_sclk", int'(scanclk), 0);
        chk("ab_sel", int'(phasecounterselect), 4);
        chk("ab_err", int'(err), 0);
        step_clk(1);
        chk("ab_done_1cyc", int'(done), 0);
        step_clk(40);
        chk("ab_pulses", n_pulse - p0, 2);
        chk("ab_done_cnt", n_done - d0, 1);

        // nsteps = 0
        p0 = n_pulse;
        start(1, 0, 0);
        chk("z_done", int'(done), 1);
        chk("z_busy", int'(busy), 0);
        chk("z_pstep", int'(phasestep), 0);
        chk("z_sel", int'(phasecounterselect), 4);
        chk("z_up", int'(phaseupdown), 1);
        step_clk(1);
        chk("z_done_1cyc", int'(done), 0);
        step_clk(10);
        chk("z_pulses", n_pulse - p0, 0);

        // back-to-back: req in the done cycle
        pll_low = 10;
        start(2, 1, 1);
        wait_done(200, ok);
        chk("bb_done1", int'(done), 1);
        req_sel    = 3'd5;
        req_up     = 1'b0;
        req_nsteps = 8'd2;
        exp_sel    = 3'd5;
        exp_up     = 1'b0;
        req = 1'b1;
        step_clk(1);
        req = 1'b0;
        chk("bb_busy", int'(busy), 1);
        chk("bb_up", int'(phaseupdown), 0);
        chk("bb_sel", int'(phasecounterselect), 5);
        wait_done(400, ok);
        if (ok) chk("bb_steps", int'(steps_done), 2);
        step_clk(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
